// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state enum and frame constants for the UART retransmit transmitter
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_RESP
   } tx_state_e;

   localparam logic START_BIT = 1'b1;
   localparam logic STOP_BIT  = 1'b1;
   localparam logic IDLE_LVL  = 1'b0;
   localparam int   RETRY_W   = 5;

endpackage

// File: rtl/uart_retrans_tx_if.sv
// rtl/uart_retrans_tx_if.sv - requester, serial line and receiver-verdict signals of the transmitter
interface uart_retrans_tx_if #(parameter int DATA_W = 8);
   import uart_pkg::*;

   logic               send;
   logic [DATA_W-1:0]  data;
   logic               inject_err;
   logic               resend_req;
   logic               rx_valid;
   logic               tx;
   logic               ready;
   logic               done;
   logic               fail;
   logic [RETRY_W-1:0] retry_count;

   modport master (
      output send, data, inject_err, resend_req, rx_valid,
      input  tx, ready, done, fail, retry_count
   );

   modport slave (
      input  send, data, inject_err, resend_req, rx_valid,
      output tx, ready, done, fail, retry_count
   );

endinterface

// File: rtl/uart_retrans_tx_fsm.sv
// rtl/uart_retrans_tx_fsm.sv - frame sequencing FSM with bit, bit-index and response-timeout counters
module uart_retrans_tx_fsm
   import uart_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 1,
   parameter int RESP_TIMEOUT = 8,
   parameter int BW           = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          send,
   input  logic          rx_valid,
   input  logic          resend_req,
   input  logic          at_limit,
   output tx_state_e     state,
   output tx_state_e     state_nx,
   output logic [BW-1:0] bit_nx,
   output logic          ready,
   output logic          accept,
   output logic          retry,
   output logic          ack,
   output logic          exhaust
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int TW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(RESP_TIMEOUT - 1);

   logic [BW-1:0] bit_q;
   logic [CW-1:0] cnt_q, cnt_nx;
   logic [TW-1:0] tmo_q, tmo_nx;
   logic          bit_end, resp_evt;

   assign bit_end  = (cnt_q == CNT_LAST);
   assign resp_evt = resend_req || (tmo_q == TMO_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         bit_q <= '0;
         cnt_q <= '0;
         tmo_q <= '0;
      end else begin
         state <= state_nx;
         bit_q <= bit_nx;
         cnt_q <= cnt_nx;
         tmo_q <= tmo_nx;
      end
   end

   always_comb begin
      state_nx = state;
      bit_nx   = bit_q;
      cnt_nx   = cnt_q;
      tmo_nx   = '0;
      if (state inside {START, DATA, PARITY, STOP})
         cnt_nx = bit_end ? '0 : cnt_q + 1'b1;
      unique case (state)
         IDLE:   if (send) state_nx = START;
         START:  if (bit_end) begin
                    state_nx = DATA;
                    bit_nx   = '0;
                 end
         DATA:   if (bit_end) begin
                    if (bit_q == BIT_LAST) state_nx = PARITY;
                    else                   bit_nx   = bit_q + 1'b1;
                 end
         PARITY: if (bit_end) state_nx = STOP;
         STOP:   if (bit_end) state_nx = WAIT_RESP;
         WAIT_RESP: begin
            // rx_valid has priority over a simultaneous resend request
            if (rx_valid)      state_nx = IDLE;
            else if (resp_evt) state_nx = at_limit ? IDLE : START;
            else               tmo_nx   = tmo_q + 1'b1;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      ready   = (state == IDLE);
      accept  = ready && send;
      ack     = (state == WAIT_RESP) && rx_valid;
      retry   = (state == WAIT_RESP) && !rx_valid && resp_evt && !at_limit;
      exhaust = (state == WAIT_RESP) && !rx_valid && resp_evt && at_limit;
   end

endmodule

// File: rtl/uart_retrans_tx.sv
// rtl/uart_retrans_tx.sv - UART transmitter replaying a frame on receiver resend request or timeout
// Optional: UART_TX_ERR_INJECT_EN inverts the parity of the first attempt when inject_err is set.
module uart_retrans_tx
   import uart_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 1,
   parameter int MAX_RETRIES  = 5,
   parameter int RESP_TIMEOUT = 8
) (
   input  logic               clk,
   input  logic               reset,
   uart_retrans_tx_if.slave   bus
);

   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

   tx_state_e          state, state_nx;
   logic [BW-1:0]      bit_nx;
   logic               ready, accept, retry, ack, exhaust, at_limit;
   logic [DATA_W-1:0]  data_q;
   logic [RETRY_W-1:0] retry_q;
   logic               err_q, par, tx_q, tx_nx, done_q, fail_q;

   assign at_limit = (retry_q == RETRY_MAX);

   uart_retrans_tx_fsm #(
      .DATA_W       (DATA_W),
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .RESP_TIMEOUT (RESP_TIMEOUT),
      .BW           (BW)
   ) u_fsm (
      .clk        (clk),
      .reset      (reset),
      .send       (bus.send),
      .rx_valid   (bus.rx_valid),
      .resend_req (bus.resend_req),
      .at_limit   (at_limit),
      .state      (state),
      .state_nx   (state_nx),
      .bit_nx     (bit_nx),
      .ready      (ready),
      .accept     (accept),
      .retry      (retry),
      .ack        (ack),
      .exhaust    (exhaust)
   );

`ifdef UART_TX_ERR_INJECT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       err_q <= 1'b0;
      else if (accept) err_q <= bus.inject_err;
   end
`else
   assign err_q = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q  <= '0;
         retry_q <= '0;
      end else if (accept) begin
         data_q  <= bus.data;
         retry_q <= '0;
      end else if (retry) begin
         retry_q <= retry_q + 1'b1;
      end
   end

   // Only attempt 0 may carry the corrupted parity
   assign par = (^data_q) ^ (err_q && (retry_q == '0));

   // tx is registered from the next state so each bit lands right after its edge
   always_comb begin
      tx_nx = IDLE_LVL;
      unique case (state_nx)
         START:   tx_nx = START_BIT;
         DATA:    tx_nx = data_q[bit_nx];
         PARITY:  tx_nx = par;
         STOP:    tx_nx = STOP_BIT;
         default: tx_nx = IDLE_LVL;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_q   <= IDLE_LVL;
         done_q <= 1'b0;
         fail_q <= 1'b0;
      end else begin
         tx_q   <= tx_nx;
         done_q <= ack;
         fail_q <= exhaust;
      end
   end

   assign bus.tx          = tx_q;
   assign bus.ready       = ready;
   assign bus.done        = done_q;
   assign bus.fail        = fail_q;
   assign bus.retry_count = retry_q;

endmodule

// File: tb/tb_uart_retrans_tx.sv
// tb/tb_uart_retrans_tx.sv - directed-vector bench for uart_retrans_tx (default and 3-clock-per-bit builds)
module tb_uart_retrans_tx;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   uart_retrans_tx_if #(.DATA_W(8)) bus ();
   uart_retrans_tx_if #(.DATA_W(8)) bus2 ();

   uart_retrans_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .MAX_RETRIES(5), .RESP_TIMEOUT(8))
      dut (.clk(clk), .reset(reset), .bus(bus));

   uart_retrans_tx #(.DATA_W(8), .CLKS_PER_BIT(3), .MAX_RETRIES(5), .RESP_TIMEOUT(8))
      dut2 (.clk(clk), .reset(reset), .bus(bus2));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic start_send(input logic [7:0] d, input logic inj);
      bus.data       = d;
      bus.inject_err = inj;
      bus.send       = 1'b1;
      @(negedge clk);
      bus.send       = 1'b0;
      bus.inject_err = 1'b0;
   endtask

   // Samples 11 bits first-bit-at-MSB; optionally pokes send=1/data=FF mid-frame
   task automatic capture(input int poke, output logic [10:0] bits);
      for (int i = 0; i < 11; i++) begin
         bits[10-i] = bus.tx;
         if (i == poke) begin
            bus.send = 1'b1;
            bus.data = 8'hFF;
         end else begin
            bus.send = 1'b0;
         end
         @(negedge clk);
      end
   endtask

   logic [10:0] f;
   logic [32:0] got33, exp33;
   logic [10:0] f6;
   int          zeros;

   initial begin
      bus.send = 0; bus.data = 0; bus.inject_err = 0; bus.resend_req = 0; bus.rx_valid = 0;
      bus2.send = 0; bus2.data = 0; bus2.inject_err = 0; bus2.resend_req = 0; bus2.rx_valid = 0;
      repeat (3) @(negedge clk);
      check("rst_tx",    bus.tx, 0);
      check("rst_ready", bus.ready, 1);
      check("rst_done",  bus.done, 0);
      check("rst_fail",  bus.fail, 0);
      check("rst_retry", bus.retry_count, 0);
      reset = 1'b0;
      @(negedge clk);

      // basic frame 0xC4, acknowledged
      start_send(8'hC4, 1'b0);
      check("t1_ready_low", bus.ready, 0);
      capture(-1, f);
      check("t1_frame", f, 11'b10010001111);
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      check("t1_done",  bus.done, 1);
      check("t1_fail",  bus.fail, 0);
      check("t1_ready", bus.ready, 1);
      check("t1_retry", bus.retry_count, 0);
      @(negedge clk);
      check("t1_done_pulse", bus.done, 0);

      // parity error injection on first attempt, then resend
      start_send(8'hC4, 1'b1);
      capture(-1, f);
`ifdef UART_TX_ERR_INJECT_EN
      check("t2_frame0", f, 11'b10010001101);
`else
      check("t2_frame0", f, 11'b10010001111);
`endif
      bus.resend_req = 1'b1;
      @(negedge clk);
      bus.resend_req = 1'b0;
      check("t2_retry", bus.retry_count, 1);
      capture(-1, f);
      check("t2_frame1", f, 11'b10010001111);
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      check("t2_done", bus.done, 1);
      check("t2_retry_kept", bus.retry_count, 1);
      @(negedge clk);

      // no response: 6 frames spaced by 8-cycle timeouts, then fail
      start_send(8'h3C, 1'b0);
      for (int a = 0; a < 6; a++) begin
         capture(-1, f);
         check($sformatf("t3_frame%0d", a), f, 11'b10011110001);
         check($sformatf("t3_retry%0d", a), bus.retry_count, a);
         zeros = 0;
         for (int k = 0; k < 8; k++) begin
            if (bus.tx == 1'b0 && !bus.fail && !bus.done) zeros++;
            @(negedge clk);
         end
         check($sformatf("t3_gap%0d", a), zeros, 8);
      end
      check("t3_fail",  bus.fail, 1);
      check("t3_ready", bus.ready, 1);
      check("t3_retry_final", bus.retry_count, 5);
      @(negedge clk);
      check("t3_fail_pulse", bus.fail, 0);
      check("t3_retry_hold", bus.retry_count, 5);

      // simultaneous verdicts; send of 0xFF mid-frame must be ignored
      start_send(8'hA5, 1'b0);
      capture(4, f);
      check("t4_frame", f, 11'b11010010101);
      bus.rx_valid   = 1'b1;
      bus.resend_req = 1'b1;
      @(negedge clk);
      bus.rx_valid   = 1'b0;
      bus.resend_req = 1'b0;
      check("t4_done",  bus.done, 1);
      check("t4_retry", bus.retry_count, 0);
      zeros = 0;
      for (int k = 0; k < 4; k++) begin
         if (bus.tx == 1'b0) zeros++;
         @(negedge clk);
      end
      check("t4_no_retx", zeros, 4);

      // reset in the middle of a retransmission
      start_send(8'h0F, 1'b0);
      capture(-1, f);
      repeat (8) @(negedge clk);
      check("t5_retry_before", bus.retry_count, 1);
      repeat (4) @(negedge clk);
      check("t5_bit4", bus.tx, 1);
      #2 reset = 1'b1;
      #1;
      check("t5_tx_async", bus.tx, 0);
      check("t5_ready",    bus.ready, 1);
      check("t5_retry",    bus.retry_count, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      start_send(8'h01, 1'b0);
      capture(-1, f);
      check("t5_frame", f, 11'b11000000011);
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      check("t5_done", bus.done, 1);

      // three clocks per bit, data 0x80
      f6 = 11'b10000000111;
      for (int j = 0; j < 11; j++)
         for (int r = 0; r < 3; r++)
            exp33[32 - (j*3 + r)] = f6[10-j];
      bus2.data = 8'h80;
      bus2.send = 1'b1;
      @(negedge clk);
      bus2.send = 1'b0;
      for (int i = 0; i < 33; i++) begin
         got33[32-i] = bus2.tx;
         @(negedge clk);
      end
      check("t6_frame", got33, exp33);
      check("t6_end_tx", bus2.tx, 0);
      check("t6_ready",  bus2.ready, 0);
      bus2.rx_valid = 1'b1;
      @(negedge clk);
      bus2.rx_valid = 1'b0;
      check("t6_done", bus2.done, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
